// File: rtl/alu_issue_decoder_if.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder_if
// Bundles the upstream instruction handshake and the downstream ALU issue
// bundle of alu_issue_decoder into one interface.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready. The producer holds valid and its payload stable until the
// transfer. The consumer may change ready freely.
//
// Signals
//   in_valid / in_ready     upstream instruction handshake
//   in_instr, in_pc         instruction word and its PC
//   in_rs1_val, in_rs2_val  register file operands
//   out_valid / out_ready   downstream issue handshake
//   alu_a, alu_b            ALU operands
//   alu_opcode/funct3/7     ALU control fields
//   store_data, rd_addr, rd_we, illegal   side-band decode results
//   issue_count, illegal_count            issue statistics
//   dbg_state               buffer occupancy state (debug only)
// Modports
//   master : instruction source / execute stage (drives in_*, out_ready)
//   slave  : the decoder
// ---------------------------------------------------------------------------
interface alu_issue_decoder_if #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic [XLEN-1:0]      in_pc;
   logic [XLEN-1:0]      in_rs1_val;
   logic [XLEN-1:0]      in_rs2_val;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      alu_a;
   logic [XLEN-1:0]      alu_b;
   logic [6:0]           alu_opcode;
   logic [2:0]           alu_funct3;
   logic [6:0]           alu_funct7;
   logic [XLEN-1:0]      store_data;
   logic [4:0]           rd_addr;
   logic                 rd_we;
   logic                 illegal;
   logic [CNT_WIDTH-1:0] issue_count;
   logic [CNT_WIDTH-1:0] illegal_count;
   logic [1:0]           dbg_state;

   modport master (
      output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_opcode, alu_funct3,
             alu_funct7, store_data, rd_addr, rd_we, illegal,
             issue_count, illegal_count, dbg_state
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_opcode, alu_funct3,
             alu_funct7, store_data, rd_addr, rd_we, illegal,
             issue_count, illegal_count, dbg_state
   );
endinterface

// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
// RV32I/M decode stage feeding the ALU. Decodes the instruction word into
// operands a/b and control fields, flags unsupported encodings, and registers
// the bundle. A skid register behind the output register lets the stage
// accept one more instruction while the output is stalled, so nothing is
// dropped or reordered; in_ready is a decode of registered state.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (wins over any handshake)
//   bus  : alu_issue_decoder_if.slave (instruction in, issue bundle out,
//          counters, dbg_state = occupancy state)
//
// Build option
//   DECODER_RV32M_EN : when defined, OP with funct7=0x01 and funct3 0/4/6 is
//                      legal; otherwise every OP with funct7=0x01 is illegal.
// ---------------------------------------------------------------------------
module alu_issue_decoder #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   alu_issue_decoder_if.slave bus
);
   localparam logic [6:0] OPC_OP    = 7'h33;
   localparam logic [6:0] OPC_IMM   = 7'h13;
   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_JALR  = 7'h67;
   localparam logic [6:0] OPC_STORE = 7'h23;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] store_data;
      logic [4:0]      rd_addr;
      logic            rd_we;
      logic            illegal;
   } bundle_t;

   // S_EMPTY: nothing held; S_ONE: output register valid;
   // S_TWO: output register valid and skid register full.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t               state, state_next;
   bundle_t              dec, out_q, skid_q;
   logic                 load_out_dec, load_out_skid, load_skid;
   logic                 in_ready, out_valid, in_fire, out_fire;
   logic                 legal, m_legal;
   logic [CNT_WIDTH-1:0] issue_cnt, illegal_cnt;

   logic [31:0]     instr;
   logic [6:0]      f7;
   logic [2:0]      f3;
   logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt;

   assign instr = bus.in_instr;
   assign f7    = instr[31:25];
   assign f3    = instr[14:12];
   assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign u_imm = {instr[31:12], {(XLEN-20){1'b0}}};
   assign shamt = {{(XLEN-5){1'b0}}, instr[24:20]};

`ifdef DECODER_RV32M_EN
   assign m_legal = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6);
`else
   assign m_legal = 1'b0;
`endif

   // Combinational decode of the instruction currently on the input.
   always_comb begin
      dec            = '0;
      dec.opcode     = instr[6:0];
      dec.funct3     = f3;
      dec.rd_addr    = instr[11:7];
      legal          = 1'b1;
      case (instr[6:0])
         OPC_OP: begin
            dec.a      = bus.in_rs1_val;
            dec.b      = bus.in_rs2_val;
            dec.funct7 = f7;
            dec.rd_we  = 1'b1;
            legal      = (f7 == 7'h00) ||
                         ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
                         ((f7 == 7'h01) && m_legal);
         end
         OPC_IMM: begin
            dec.a     = bus.in_rs1_val;
            dec.rd_we = 1'b1;
            if ((f3 == 3'd1) || (f3 == 3'd5)) begin
               // Shifts: only the 5-bit shamt is an operand, the upper
               // field selects logical/arithmetic.
               dec.b      = shamt;
               dec.funct7 = f7;
               legal      = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd5));
            end else begin
               dec.b = i_imm;
            end
         end
         OPC_LUI: begin
            dec.b     = u_imm;
            dec.rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a     = bus.in_pc;
            dec.b     = u_imm;
            dec.rd_we = 1'b1;
         end
         OPC_LOAD, OPC_JALR: begin
            dec.a     = bus.in_rs1_val;
            dec.b     = i_imm;
            dec.rd_we = 1'b1;
         end
         OPC_STORE: begin
            dec.a          = bus.in_rs1_val;
            dec.b          = s_imm;
            dec.store_data = bus.in_rs2_val;
         end
         default: legal = 1'b0;
      endcase
      // Illegal bundles keep only opcode/funct3/rd so the execute stage
      // can still report what it saw.
      if (!legal) begin
         dec.a          = '0;
         dec.b          = '0;
         dec.funct7     = '0;
         dec.store_data = '0;
         dec.rd_we      = 1'b0;
      end
      if (dec.rd_addr == 5'd0) begin
         dec.rd_we = 1'b0;
      end
      dec.illegal = !legal;
   end

   assign in_ready  = (state != S_TWO);
   assign out_valid = (state != S_EMPTY);
   assign in_fire   = bus.in_valid && in_ready;
   assign out_fire  = out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      load_out_dec  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         S_EMPTY: begin
            if (in_fire) begin
               load_out_dec = 1'b1;
               state_next   = S_ONE;
            end
         end
         S_ONE: begin
            if (bus.out_ready) begin
               if (in_fire) begin
                  load_out_dec = 1'b1;
               end else begin
                  state_next = S_EMPTY;
               end
            end else if (in_fire) begin
               load_skid  = 1'b1;
               state_next = S_TWO;
            end
         end
         S_TWO: begin
            // in_ready is low here, so only the skid entry can move.
            if (bus.out_ready) begin
               load_out_skid = 1'b1;
               state_next    = S_ONE;
            end
         end
         default: state_next = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         skid_q      <= '0;
         issue_cnt   <= '0;
         illegal_cnt <= '0;
      end else begin
         if (load_out_dec) begin
            out_q <= dec;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= dec;
         end
         if (out_fire) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (out_q.illegal) begin
               illegal_cnt <= illegal_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid;
   assign bus.alu_a         = out_q.a;
   assign bus.alu_b         = out_q.b;
   assign bus.alu_opcode    = out_q.opcode;
   assign bus.alu_funct3    = out_q.funct3;
   assign bus.alu_funct7    = out_q.funct7;
   assign bus.store_data    = out_q.store_data;
   assign bus.rd_addr       = out_q.rd_addr;
   assign bus.rd_we         = out_q.rd_we;
   assign bus.illegal       = out_q.illegal;
   assign bus.issue_count   = issue_cnt;
   assign bus.illegal_count = illegal_cnt;
   assign bus.dbg_state     = state;
endmodule

// File: tb/tb_alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_decoder
// Self-checking bench for alu_issue_decoder. A reference model keeps the
// bundles the decoder should be holding in a queue (front = output register)
// and predicts handshake, bundle contents and counters every cycle.
// ---------------------------------------------------------------------------
module tb_alu_issue_decoder;
   localparam int XLEN = 32;
   localparam int CW   = 32;
`ifdef DECODER_RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] store_data;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic        illegal;
   } exp_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_issue_decoder_if #(.XLEN(XLEN), .CNT_WIDTH(CW)) bus ();

   alu_issue_decoder #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // scoreboard
   exp_t        exp_q[$];
   int unsigned exp_issue;
   int unsigned exp_illegal;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference decode, straight from the instruction-set rules.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t              e;
      logic signed [11:0] i12;
      logic signed [11:0] s12;
      logic [6:0]        op;
      logic [6:0]        f7;
      logic [2:0]        f3;
      bit                ok;
      op  = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      i12 = ins[31:20];
      s12 = {ins[31:25], ins[11:7]};
      e   = '0;
      e.opcode  = op;
      e.funct3  = f3;
      e.rd_addr = ins[11:7];
      ok = 1'b1;
      case (op)
         7'h33: begin
            e.a = r1; e.b = r2; e.funct7 = f7; e.rd_we = 1'b1;
            ok = (f7 == 7'h00) ||
                 (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) ||
                 (M_EN && f7 == 7'h01 && (f3 inside {3'd0, 3'd4, 3'd6}));
         end
         7'h13: begin
            e.a = r1; e.rd_we = 1'b1;
            if (f3 inside {3'd1, 3'd5}) begin
               e.b      = 32'(ins[24:20]);
               e.funct7 = f7;
               ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
            end else begin
               e.b = 32'(int'(i12));
            end
         end
         7'h37: begin e.a = 32'd0; e.b = 32'(ins[31:12]) << 12; e.rd_we = 1'b1; end
         7'h17: begin e.a = pc;    e.b = 32'(ins[31:12]) << 12; e.rd_we = 1'b1; end
         7'h03, 7'h67: begin e.a = r1; e.b = 32'(int'(i12)); e.rd_we = 1'b1; end
         7'h23: begin e.a = r1; e.b = 32'(int'(s12)); e.store_data = r2; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.a = '0; e.b = '0; e.funct7 = '0; e.store_data = '0; e.rd_we = 1'b0;
      end
      if (e.rd_addr == 5'd0) e.rd_we = 1'b0;
      e.illegal = !ok;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  ops [8];
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h67, 7'h23, 7'h7f};
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 7)];
      if (w[6:0] == 7'h7f) w[6:0] = 7'($urandom());
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         2: w[31:25] = 7'h01;
         default: ;
      endcase
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   task automatic check_outputs();
      exp_t e;
      chk("in_ready",      64'(bus.in_ready),      64'(exp_q.size() < 2));
      chk("out_valid",     64'(bus.out_valid),     64'(exp_q.size() != 0));
      chk("issue_count",   64'(bus.issue_count),   64'(exp_issue));
      chk("illegal_count", 64'(bus.illegal_count), 64'(exp_illegal));
      if (exp_q.size() != 0) begin
         e = exp_q[0];
         chk("alu_a",      64'(bus.alu_a),      64'(e.a));
         chk("alu_b",      64'(bus.alu_b),      64'(e.b));
         chk("alu_opcode", 64'(bus.alu_opcode), 64'(e.opcode));
         chk("alu_funct3", 64'(bus.alu_funct3), 64'(e.funct3));
         chk("alu_funct7", 64'(bus.alu_funct7), 64'(e.funct7));
         chk("store_data", 64'(bus.store_data), 64'(e.store_data));
         chk("rd_addr",    64'(bus.rd_addr),    64'(e.rd_addr));
         chk("rd_we",      64'(bus.rd_we),      64'(e.rd_we));
         chk("illegal",    64'(bus.illegal),    64'(e.illegal));
      end
   endtask

   // driver: one clock cycle. Checks the state left by the previous edge,
   // then drives this cycle's inputs and advances the model to match.
   task automatic cycle(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, output bit accepted);
      @(negedge clk);
      check_outputs();
      rst            = r;
      bus.in_valid   = v;
      bus.in_instr   = ins;
      bus.in_pc      = pc;
      bus.in_rs1_val = r1;
      bus.in_rs2_val = r2;
      bus.out_ready  = ordy;
      accepted = !r && v && (exp_q.size() < 2);
      if (r) begin
         exp_q.delete();
         exp_issue   = 0;
         exp_illegal = 0;
      end else begin
         if (exp_q.size() != 0 && ordy) begin
            exp_issue++;
            if (exp_q[0].illegal) exp_illegal++;
            void'(exp_q.pop_front());
         end
         if (accepted) exp_q.push_back(ref_decode(ins, pc, r1, r2));
      end
   endtask

   task automatic peek_reset();
      @(negedge clk);
      chk("rst_out_valid",     64'(bus.out_valid),     64'(0));
      chk("rst_in_ready",      64'(bus.in_ready),      64'(1));
      chk("rst_issue_count",   64'(bus.issue_count),   64'(0));
      chk("rst_illegal_count", 64'(bus.illegal_count), 64'(0));
      chk("rst_alu_a",         64'(bus.alu_a),         64'(0));
      chk("rst_alu_b",         64'(bus.alu_b),         64'(0));
      chk("rst_ctrl",          64'({bus.alu_opcode, bus.alu_funct3, bus.alu_funct7}), 64'(0));
      chk("rst_side",          64'({bus.store_data, bus.rd_addr, bus.rd_we, bus.illegal}), 64'(0));
      chk("rst_dbg_known",     64'($isunknown(bus.dbg_state)), 64'(0));
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] dir_i [12];
      logic [31:0] dir_r1 [12];
      logic [31:0] dir_r2 [12];
      logic [31:0] cur_i, cur_pc, cur_r1, cur_r2;
      bit          have, acc;
      int          n;

      exp_issue   = 0;
      exp_illegal = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
      bus.in_rs1_val = '0; bus.in_rs2_val = '0; bus.out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      peek_reset();

      // directed decode cases, back to back with no backpressure
      dir_i  = '{32'h00500093, 32'hFFF00093, 32'h402081B3, 32'h123452B7,
                 32'h0020A423, 32'h022081B3, 32'h00001297, 32'h0000007F,
                 32'h00100013, 32'h4030D093, 32'h40309093, 32'h402091B3};
      dir_r1 = '{32'h0, 32'h0, 32'd7, 32'h0, 32'h100, 32'd6, 32'h0, 32'h55,
                 32'h0, 32'h80000000, 32'h1, 32'h9};
      dir_r2 = '{32'h0, 32'h0, 32'd3, 32'h0, 32'hDEADBEEF, 32'd7, 32'h0, 32'h66,
                 32'h0, 32'h0, 32'h0, 32'h4};
      for (int k = 0; k < 12; k++)
         cycle(1'b0, 1'b1, dir_i[k], 32'h0000_4000 + 32'(k * 4), dir_r1[k], dir_r2[k], 1'b1, acc);
      idle(2);

      // backpressure: three back-to-back with out_ready low, then drain
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, dir_i[k + 2], 32'h100, 32'(k + 1), 32'(k + 10), 1'b0, acc);
      n = 0;
      do begin
         cycle(1'b0, 1'b1, dir_i[4], 32'h100, 32'd3, 32'd12, 1'b1, acc);
         n++;
      end while (!acc && n < 10);
      chk("bp_third_accepted_in_bound", 64'(acc), 64'(1));
      idle(3);

      // randomized traffic, upstream holds each instruction until accepted
      have = 1'b0;
      cur_i = '0; cur_pc = '0; cur_r1 = '0; cur_r2 = '0;
      for (int t = 0; t < 800; t++) begin
         if (!have) begin
            cur_i  = rand_instr();
            cur_pc = $urandom() & 32'hFFFF_FFFC;
            cur_r1 = $urandom();
            cur_r2 = $urandom();
            have   = ($urandom_range(0, 3) != 0);
         end
         cycle(1'b0, have, cur_i, cur_pc, cur_r1, cur_r2,
               (t < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0), acc);
         if (acc) have = 1'b0;
      end
      idle(3);

      // reset while the output is stalled and the skid entry is full
      cycle(1'b0, 1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0, 1'b0, acc);
      cycle(1'b0, 1'b1, 32'h402081B3, 32'h0, 32'd7, 32'd3, 1'b0, acc);
      cycle(1'b1, 1'b1, 32'h123452B7, 32'h0, 32'h0, 32'h0, 1'b1, acc);
      peek_reset();
      idle(2);
      cycle(1'b0, 1'b1, 32'h0020A423, 32'h0, 32'h100, 32'h1234, 1'b1, acc);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
